// File: rtl/truth_table_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer_pkg
// Shared definitions for the truth-table sweep controller: FSM state encoding,
// default parameter values and a helper that sizes the settle counter.
// -----------------------------------------------------------------------------
package truth_table_sequencer_pkg;

  // Encodings are fixed so waveforms and any host-side decoding stay stable.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_N_IN   = 2;
  localparam int DEF_SETTLE = 1;

  // Counter must hold SETTLE-1; never let the width collapse to zero.
  function automatic int timer_width(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that measures how long a vector is held on the
// function under test before its output is sampled.
//   clk, rst_n     : clock, asynchronous active-low reset (count -> 0)
//   i_load         : load i_load_value (has priority over decrement)
//   i_load_value   : reload value
//   i_dec          : decrement by one
//   o_value        : current count
//   o_zero         : count is zero
// -----------------------------------------------------------------------------
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_value = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
// Sweeps every input combination of a combinational function f(vec_out),
// holds each vector SETTLE cycles, samples f_in, builds the truth table and
// compares it against a latched expected table.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : sweep request, honoured only in IDLE
//   expected     : expected table (bit i = output for vector i), latched on start
//   f_in         : output of the function under test
//   vec_out      : vector driven onto the function inputs
//   busy         : sweep in progress (DRIVE/SAMPLE)
//   done         : one-cycle pulse at sweep end, results valid in that cycle
//   table_out    : captured truth table
//   pass         : table_out matched expected
//   fail_count   : number of mismatching vectors
//   first_fail   : lowest mismatching vector index (0 if none)
// -----------------------------------------------------------------------------
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail
);

  localparam int                N_VEC    = 2**N_IN;
  localparam int                CW       = timer_width(SETTLE);
  localparam logic [CW-1:0]     RELOAD   = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   LAST_VEC = {N_IN{1'b1}};

  state_e               r_state, w_state_nxt;
  logic [N_IN-1:0]      r_vec;
  logic                 r_busy, r_done, r_pass;
  logic [N_VEC-1:0]     r_table, r_expected;
  logic [N_IN:0]        r_fail_count;
  logic [N_IN-1:0]      r_first_fail;

  logic                 w_accept, w_last, w_mismatch;
  logic                 w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [CW-1:0]        w_tmr_value;
  logic                 w_busy_nxt, w_done_nxt;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_last     = (r_vec == LAST_VEC);
  assign w_mismatch = f_in ^ r_expected[r_vec];

  settle_timer #(.W(CW)) u_settle_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_tmr_load),
    .i_load_value (RELOAD),
    .i_dec        (w_tmr_dec),
    .o_value      (w_tmr_value),
    .o_zero       (w_tmr_zero)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start)      w_state_nxt = ST_DRIVE;
      ST_DRIVE:  if (w_tmr_zero) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (timer control and next values of the registered flags)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tmr_load = w_accept || ((r_state == ST_SAMPLE) && !w_last);
    w_tmr_dec  = (r_state == ST_DRIVE) && (w_tmr_value != '0);
    w_busy_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Capture and comparison datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_table      <= '0;
      r_expected   <= '0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_expected   <= expected;
            r_table      <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
            r_vec        <= '0;
          end
        end
        ST_SAMPLE: begin
          r_table[r_vec] <= f_in;
          if (w_mismatch) begin
            r_fail_count <= r_fail_count + (N_IN+1)'(1);
            if (r_fail_count == '0) r_first_fail <= r_vec;
          end
          if (w_last) begin
            // Resolve pass here, including this edge's mismatch, so it is
            // already valid during the single DONE cycle.
            r_pass <= (r_fail_count == '0) && !w_mismatch;
          end else begin
            r_vec <= r_vec + N_IN'(1);
          end
        end
        ST_DONE: begin
          r_pass <= (r_fail_count == '0);
          r_vec  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign vec_out    = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign table_out  = r_table;
  assign pass       = r_pass;
  assign fail_count = r_fail_count;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sequencer
// Three sequencer instances (defaults, SETTLE=3, N_IN=3) each driving its own
// function under test. A behavioural model derives the expected table
// statistics and sweep timing from the vector count and settle interval.
// -----------------------------------------------------------------------------
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] exp_bus;
  logic       start0, start1, start2;
  logic       use_gate, use_xor;
  logic [3:0] tt0, tt1;
  logic [7:0] tt2;

  // Default instance
  logic [1:0] vec0; logic busy0, done0, pass0, f0;
  logic [3:0] tbl0; logic [2:0] fc0; logic [1:0] ff0;
  // SETTLE = 3
  logic [1:0] vec1; logic busy1, done1, pass1, f1;
  logic [3:0] tbl1; logic [2:0] fc1; logic [1:0] ff1;
  // N_IN = 3
  logic [2:0] vec2; logic busy2, done2, pass2, f2;
  logic [7:0] tbl2; logic [3:0] fc2; logic [2:0] ff2;

  // The lab's reference gate: NOT(NAND(XOR(a,b), NOR(a, NOT b)))
  function automatic logic gate(input logic a, input logic b);
    return ~(~((a ^ b) & ~(a | ~b)));
  endfunction

  assign f0 = use_gate ? gate(vec0[1], vec0[0]) : tt0[vec0];
  assign f1 = use_gate ? gate(vec1[1], vec1[0]) : tt1[vec1];
  assign f2 = use_xor  ? ^vec2                  : tt2[vec2];

  truth_table_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp_bus[3:0]),
    .f_in(f0), .vec_out(vec0), .busy(busy0), .done(done0),
    .table_out(tbl0), .pass(pass0), .fail_count(fc0), .first_fail(ff0)
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp_bus[3:0]),
    .f_in(f1), .vec_out(vec1), .busy(busy1), .done(done1),
    .table_out(tbl1), .pass(pass1), .fail_count(fc1), .first_fail(ff1)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp_bus),
    .f_in(f2), .vec_out(vec2), .busy(busy2), .done(done2),
    .table_out(tbl2), .pass(pass2), .fail_count(fc2), .first_fail(ff2)
  );

  // View of the instance currently under test
  int          cur;
  logic [31:0] s_vec, s_busy, s_done, s_tbl, s_pass, s_fc, s_ff;
  always_comb begin
    s_vec = '0; s_busy = '0; s_done = '0; s_tbl = '0;
    s_pass = '0; s_fc = '0; s_ff = '0;
    case (cur)
      0: begin
        s_vec = 32'(vec0); s_busy = 32'(busy0); s_done = 32'(done0);
        s_tbl = 32'(tbl0); s_pass = 32'(pass0); s_fc = 32'(fc0); s_ff = 32'(ff0);
      end
      1: begin
        s_vec = 32'(vec1); s_busy = 32'(busy1); s_done = 32'(done1);
        s_tbl = 32'(tbl1); s_pass = 32'(pass1); s_fc = 32'(fc1); s_ff = 32'(ff1);
      end
      default: begin
        s_vec = 32'(vec2); s_busy = 32'(busy2); s_done = 32'(done2);
        s_tbl = 32'(tbl2); s_pass = 32'(pass2); s_fc = 32'(fc2); s_ff = 32'(ff2);
      end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int nin_of(input int sel);
    return (sel == 2) ? 3 : 2;
  endfunction

  function automatic int settle_of(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  task automatic set_start(input int sel, input logic v);
    start0 = (sel == 0) && v;
    start1 = (sel == 1) && v;
    start2 = (sel == 2) && v;
  endtask

  // Reference: count mismatches and locate the lowest one.
  task automatic model(input logic [7:0] tbl, input logic [7:0] ex, input int n,
                       output int fails, output int first);
    fails = 0;
    first = -1;
    for (int i = 0; i < (1 << n); i++) begin
      if (tbl[i] != ex[i]) begin
        fails++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
  endtask

  // One sweep on instance sel, checked against the model. mtbl is the table
  // the function under test is known to produce.
  task automatic run_check(input int sel, input logic [7:0] ex, input logic [7:0] mtbl,
                           input bit poke_mid, input bit poke_done, input string tag);
    int n, s, nv, cyc, busy_cyc, hold_err, fails, first;
    bit got;
    logic [7:0] mask;
    cur = sel;
    n   = nin_of(sel);
    s   = settle_of(sel);
    nv  = 1 << n;
    mask = (n == 3) ? 8'hFF : 8'h0F;
    cyc = 0; busy_cyc = 0; hold_err = 0; got = 0;

    @(negedge clk);
    exp_bus = ex;
    set_start(sel, 1'b1);
    while (cyc < 500) begin
      @(negedge clk);
      cyc++;
      set_start(sel, poke_mid && (cyc == 4));
      if (cyc == 3) exp_bus = ~ex;           // must not disturb a running sweep
      if (s_busy[0]) begin
        busy_cyc++;
        if (s_vec != 32'((cyc - 1) / (s + 1))) hold_err++;
      end
      if (s_done[0]) begin
        got = 1;
        break;
      end
    end
    if (!got) cyc = -1;

    model(mtbl & mask, ex, n, fails, first);
    check({tag, "/done_cycle"}, 32'(cyc), 32'(nv * (s + 1) + 1));
    check({tag, "/busy_cycles"}, 32'(busy_cyc), 32'(nv * (s + 1)));
    check({tag, "/vec_hold"}, 32'(hold_err), 32'd0);
    check({tag, "/table"}, s_tbl, 32'(mtbl & mask));
    check({tag, "/pass"}, s_pass, 32'(fails == 0));
    check({tag, "/fail_count"}, s_fc, 32'(fails));
    check({tag, "/first_fail"}, s_ff, 32'(first));

    set_start(sel, poke_done);
    @(negedge clk);
    set_start(sel, 1'b0);
    check({tag, "/done_pulse"}, s_done, 32'd0);
    check({tag, "/busy_after"}, s_busy, 32'd0);
    check({tag, "/vec_return"}, s_vec, 32'd0);
    if (poke_done) begin
      repeat (3) @(negedge clk);
      check({tag, "/no_restart"}, s_busy | s_done, 32'd0);
      check({tag, "/table_kept"}, s_tbl, 32'(mtbl & mask));
      check({tag, "/pass_kept"}, s_pass, 32'(fails == 0));
    end
  endtask

  initial begin
    logic [7:0] tt, ex;
    int sel, waited, done_seen;

    rst_n = 1'b0;
    set_start(0, 1'b0);
    exp_bus = '0;
    use_gate = 1'b1; use_xor = 1'b1;
    tt0 = '0; tt1 = '0; tt2 = '0;
    cur = 0;

    repeat (2) @(negedge clk);
    check("rst/vec_out",    32'(vec0), 32'd0);
    check("rst/busy",       32'(busy0), 32'd0);
    check("rst/done",       32'(done0), 32'd0);
    check("rst/table_out",  32'(tbl0), 32'd0);
    check("rst/pass",       32'(pass0), 32'd0);
    check("rst/fail_count", 32'(fc0), 32'd0);
    check("rst/first_fail", 32'(ff0), 32'd0);
    rst_n = 1'b1;

    // Known gate and wrong expectations (gate table is 4'b0010)
    run_check(0, 8'h02, 8'h02, 1'b0, 1'b0, "gate");
    run_check(0, 8'h0A, 8'h02, 1'b0, 1'b0, "wrong_one");
    check("wrong_one/ff_is_3", s_ff, 32'd3);
    run_check(0, 8'h0D, 8'h02, 1'b0, 1'b0, "wrong_all");
    check("wrong_all/fc_is_4", s_fc, 32'd4);

    // Longer settle interval
    run_check(1, 8'h02, 8'h02, 1'b0, 1'b0, "settle3");

    // Start pulses mid-sweep and in the DONE cycle
    run_check(0, 8'h0A, 8'h02, 1'b1, 1'b1, "start_ignored");

    // Asynchronous reset in the middle of vector 2
    cur = 0;
    @(negedge clk);
    exp_bus = 8'h02;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    waited = 0;
    while (vec0 != 2'd2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("mid_rst/reach_vec2", 32'(vec0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst/outputs_zero",
          32'({vec0, busy0, done0, tbl0, pass0, fc0, ff0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) done_seen++;
    end
    check("mid_rst/no_done", 32'(done_seen), 32'd0);
    run_check(0, 8'h02, 8'h02, 1'b0, 1'b0, "post_rst");

    // Three-input XOR
    run_check(2, 8'h96, 8'h96, 1'b0, 1'b0, "xor3");

    // Randomized functions and expectations on all three instances
    use_gate = 1'b0;
    use_xor  = 1'b0;
    for (int it = 0; it < 12; it++) begin
      sel = int'($urandom_range(0, 2));
      tt  = 8'($urandom);
      ex  = ($urandom_range(0, 3) == 0) ? tt : 8'($urandom);
      tt0 = tt[3:0]; tt1 = tt[3:0]; tt2 = tt;
      run_check(sel, ex, tt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
